count_uart_tx: RTL and testbench

COUNT_UART_TX -- requirements
Module: count_uart_tx

---
 rtl/count_uart_tx.sv | 196 +++++++++++++++++++
 tb/tb_count_uart_tx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_uart_tx.sv
// Saturating 16-bit interval counter with a UART 8N1 transmitter.
// Each accepted LOAD edge sends the frame A5, count[15:8], count[7:0], {7'b0, ovf}.
module count_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        SYS_CLK,
    input  logic        A_RESET,
    input  logic        INC,
    input  logic        SCLR,
    input  logic        LOAD,
    output logic        TX_SER,
    output logic        TX_BUSY,
    output logic        DONE,
    output logic        LOAD_DROP,
    output logic [15:0] COUNT,
    output logic        OVF
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic [7:0]  sh_q, sh_d;
    logic [15:0] snap_q, snap_d;
    logic        snap_ovf_q, snap_ovf_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        drop_q, drop_d;
    logic        load_q;
    logic [15:0] count_q, count_d;
    logic        ovf_q, ovf_d;

    logic [16:0] inc_res;
    logic        load_edge;
    logic        accept;
    logic        baud_end;

    // Returns {saturated, value}; the count sticks at 0xFFFF rather than wrapping.
    function automatic logic [16:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF)
            return {1'b1, 16'hFFFF};
        return {1'b0, v + 16'd1};
    endfunction

    function automatic logic [7:0] frame_byte(input logic [1:0] idx,
                                              input logic [15:0] snap,
                                              input logic snap_ovf);
        case (idx)
            2'd0:    return 8'hA5;
            2'd1:    return snap[15:8];
            2'd2:    return snap[7:0];
            default: return {7'b0, snap_ovf};
        endcase
    endfunction

    assign inc_res   = sat_inc16(count_q);
    assign load_edge = LOAD & ~load_q;
    // The DONE cycle still counts as busy so an edge there is dropped.
    assign accept    = load_edge & ~busy_q & ~done_q;
    assign baud_end  = (baud_q == BAUD_LAST);

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (SCLR) begin
            count_d = 16'd0;
            ovf_d   = 1'b0;
        end else if (INC) begin
            count_d = inc_res[15:0];
            ovf_d   = ovf_q | inc_res[16];
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        sh_d       = sh_q;
        snap_d     = snap_q;
        snap_ovf_d = snap_ovf_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        drop_d     = load_edge & (busy_q | done_q);

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (accept) begin
                    state_d    = START;
                    baud_d     = 16'd0;
                    byte_d     = 2'd0;
                    sh_d       = frame_byte(2'd0, count_q, ovf_q);
                    snap_d     = count_q;
                    snap_ovf_d = ovf_q;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = 16'd0;
                    state_d = DATA;
                    bit_d   = 3'd0;
                    tx_d    = sh_q[0];
                    sh_d    = sh_q >> 1;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = 16'd0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = sh_q[0];
                        sh_d  = sh_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = 16'd0;
                    if (byte_q == 2'd3) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                    end else begin
                        byte_d  = byte_q + 2'd1;
                        state_d = START;
                        tx_d    = 1'b0;
                        sh_d    = frame_byte(byte_q + 2'd1, snap_q, snap_ovf_q);
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge SYS_CLK or posedge A_RESET) begin
        if (A_RESET) begin
            state_q    <= IDLE;
            baud_q     <= 16'd0;
            bit_q      <= 3'd0;
            byte_q     <= 2'd0;
            sh_q       <= 8'd0;
            snap_q     <= 16'd0;
            snap_ovf_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
            load_q     <= 1'b1;
            count_q    <= 16'd0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            sh_q       <= sh_d;
            snap_q     <= snap_d;
            snap_ovf_q <= snap_ovf_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
            load_q     <= LOAD;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    assign TX_SER    = tx_q;
    assign TX_BUSY   = busy_q;
    assign DONE      = done_q;
    assign LOAD_DROP = drop_q;
    assign COUNT     = count_q;
    assign OVF       = ovf_q;

endmodule

// File: tb/tb_count_uart_tx.sv
// Directed bench for count_uart_tx at CLKS_PER_BIT=4 with a serial-line byte decoder.
module tb_count_uart_tx;

    localparam int CPB = 4;

    logic        SYS_CLK = 1'b0;
    logic        A_RESET, INC, SCLR, LOAD;
    logic        TX_SER, TX_BUSY, DONE, LOAD_DROP, OVF;
    logic [15:0] COUNT;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] rx_q[$];
    int rst_events  = 0;
    int busy_cycles = 0;
    int done_pulses = 0;
    int drop_pulses = 0;
    int stop_errs   = 0;

    count_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .SYS_CLK(SYS_CLK), .A_RESET(A_RESET), .INC(INC), .SCLR(SCLR), .LOAD(LOAD),
        .TX_SER(TX_SER), .TX_BUSY(TX_BUSY), .DONE(DONE), .LOAD_DROP(LOAD_DROP),
        .COUNT(COUNT), .OVF(OVF)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    always @(posedge A_RESET) rst_events++;

    always @(negedge SYS_CLK) begin
        if (TX_BUSY === 1'b1)   busy_cycles++;
        if (DONE === 1'b1)      done_pulses++;
        if (LOAD_DROP === 1'b1) drop_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line decoder: first low sample is half a cycle into the start bit, then sample mid-bit.
    task automatic rx_byte();
        logic [7:0] b;
        logic       s;
        int         r0;
        r0 = rst_events;
        b  = 8'd0;
        @(negedge SYS_CLK);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge SYS_CLK);
            b[i] = TX_SER;
        end
        repeat (CPB) @(negedge SYS_CLK);
        s = TX_SER;
        if (r0 == rst_events && A_RESET === 1'b0) begin
            rx_q.push_back(b);
            if (s !== 1'b1) stop_errs++;
        end
    endtask

    initial forever begin
        @(negedge SYS_CLK);
        if (A_RESET === 1'b0 && TX_SER === 1'b0) rx_byte();
    end

    task automatic clear_stats();
        busy_cycles = 0;
        done_pulses = 0;
        drop_pulses = 0;
        rx_q.delete();
    endtask

    // Returns at the negedge where DONE is high; TX_BUSY must already be low there.
    task automatic wait_frame(input string tag);
        int k;
        k = 0;
        while (DONE !== 1'b1 && k < 400) begin
            @(negedge SYS_CLK);
            k++;
        end
        chk({tag, "_done_seen"}, {31'd0, DONE}, 32'd1);
        chk({tag, "_busy_at_done"}, {31'd0, TX_BUSY}, 32'd0);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] exp[4];
        logic [7:0] got;
        exp[0] = 8'hA5; exp[1] = b1; exp[2] = b2; exp[3] = b3;
        chk({tag, "_nbytes"}, rx_q.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            chk($sformatf("%s_byte%0d", tag, i), {24'd0, got}, {24'd0, exp[i]});
        end
        rx_q.delete();
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge SYS_CLK);
        #1;
    endtask

    initial begin
        A_RESET = 1'b1; INC = 1'b0; SCLR = 1'b0; LOAD = 1'b0;
        step(3);
        chk("rst_tx", {31'd0, TX_SER}, 32'd1);
        chk("rst_busy", {31'd0, TX_BUSY}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_drop", {31'd0, LOAD_DROP}, 32'd0);
        chk("rst_count", {16'd0, COUNT}, 32'd0);
        chk("rst_ovf", {31'd0, OVF}, 32'd0);
        A_RESET = 1'b0;
        step(2);

        // Basic frame: 300 increments -> 0x012C
        SCLR = 1'b1; step(1); SCLR = 1'b0;
        INC = 1'b1; step(300); INC = 1'b0;
        chk("t1_count", {16'd0, COUNT}, 32'd300);
        clear_stats();
        LOAD = 1'b1; step(1);
        chk("t1_busy_start", {31'd0, TX_BUSY}, 32'd1);
        chk("t1_tx_start", {31'd0, TX_SER}, 32'd0);
        wait_frame("t1");
        step(3);
        check_frame("t1", 8'h01, 8'h2C, 8'h00);
        chk("t1_busy_cycles", busy_cycles, 32'd160);
        chk("t1_done_pulses", done_pulses, 32'd1);
        chk("t1_drops", drop_pulses, 32'd0);
        LOAD = 1'b0;

        // SCLR wins over INC
        SCLR = 1'b1; INC = 1'b1; step(10);
        chk("t3_count", {16'd0, COUNT}, 32'd0);
        SCLR = 1'b0; INC = 1'b0;

        // LOAD edge together with INC: snapshot excludes that increment
        INC = 1'b1; step(5);
        chk("t6_count5", {16'd0, COUNT}, 32'd5);
        LOAD = 1'b1; step(1); INC = 1'b0;
        chk("t6_count6", {16'd0, COUNT}, 32'd6);
        clear_stats();
        wait_frame("t6");
        step(3);
        check_frame("t6", 8'h00, 8'h05, 8'h00);
        LOAD = 1'b0;

        // Second LOAD edge mid-frame is dropped; SCLR mid-frame leaves snapshot intact
        SCLR = 1'b1; step(1); SCLR = 1'b0;
        INC = 1'b1; step(18); INC = 1'b0;
        clear_stats();
        LOAD = 1'b1; step(1);
        step(19);
        SCLR = 1'b1; step(1); SCLR = 1'b0;
        chk("t4_count_cleared", {16'd0, COUNT}, 32'd0);
        LOAD = 1'b0; step(28);
        LOAD = 1'b1;
        wait_frame("t4");
        step(60);
        check_frame("t4", 8'h00, 8'h12, 8'h00);
        chk("t4_drops", drop_pulses, 32'd1);
        chk("t4_done_pulses", done_pulses, 32'd1);
        chk("t4_busy_cycles", busy_cycles, 32'd160);
        chk("t4_idle_after", {31'd0, TX_BUSY}, 32'd0);
        LOAD = 1'b0; step(1);

        // LOAD edge in the DONE cycle is dropped
        clear_stats();
        LOAD = 1'b1; step(1); LOAD = 1'b0;
        wait_frame("t7");
        LOAD = 1'b1;
        step(60);
        chk("t7_drops", drop_pulses, 32'd1);
        chk("t7_busy_cycles", busy_cycles, 32'd160);
        check_frame("t7", 8'h00, 8'h00, 8'h00);

        // Reset mid-frame aborts it; LOAD high at release starts nothing
        LOAD = 1'b0; INC = 1'b1; step(3); INC = 1'b0;
        clear_stats();
        LOAD = 1'b1; step(1);
        step(79);
        #2 A_RESET = 1'b1;
        #1;
        chk("t5_rst_tx", {31'd0, TX_SER}, 32'd1);
        chk("t5_rst_busy", {31'd0, TX_BUSY}, 32'd0);
        chk("t5_rst_count", {16'd0, COUNT}, 32'd0);
        rx_q.delete();
        step(1);
        A_RESET = 1'b0;
        busy_cycles = 0;
        step(100);
        chk("t5_no_busy", busy_cycles, 32'd0);
        chk("t5_no_bytes", rx_q.size(), 32'd0);
        chk("t5_line_idle", {31'd0, TX_SER}, 32'd1);

        // Saturation: 70000 increments
        LOAD = 1'b0;
        SCLR = 1'b1; step(1); SCLR = 1'b0;
        INC = 1'b1; step(70000); INC = 1'b0;
        chk("t2_count", {16'd0, COUNT}, 32'h0000FFFF);
        chk("t2_ovf", {31'd0, OVF}, 32'd1);
        clear_stats();
        LOAD = 1'b1; step(1);
        wait_frame("t2");
        step(3);
        check_frame("t2", 8'hFF, 8'hFF, 8'h01);
        chk("t2_ovf_sticky", {31'd0, OVF}, 32'd1);
        SCLR = 1'b1; step(1); SCLR = 1'b0;
        chk("t2_ovf_cleared", {31'd0, OVF}, 32'd0);
        chk("t2_count_cleared", {16'd0, COUNT}, 32'd0);

        chk("stop_bits", stop_errs, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
